// File: rtl/bin2bcd_8_pkg.sv
// Shared constants for the 8-bit binary-to-BCD converter: FSM codes,
// widths, iteration bound and 7-segment patterns (gfedcba, active-high).
package bin2bcd_8_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CONV = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam int         BCD_DIGITS = 3;
    localparam int         BIN_W      = 8;
    localparam logic [2:0] ITER_LAST  = 3'd7;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Non-decimal nibbles blank the digit rather than showing garbage.
    function automatic logic [6:0] seg7_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg7_decode = SEG_0;
            4'd1:    seg7_decode = SEG_1;
            4'd2:    seg7_decode = SEG_2;
            4'd3:    seg7_decode = SEG_3;
            4'd4:    seg7_decode = SEG_4;
            4'd5:    seg7_decode = SEG_5;
            4'd6:    seg7_decode = SEG_6;
            4'd7:    seg7_decode = SEG_7;
            4'd8:    seg7_decode = SEG_8;
            4'd9:    seg7_decode = SEG_9;
            default: seg7_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_8_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Conditional add-3.
    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/bin2bcd_8.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one
// iteration per clock, 8 iterations). Optional 7-segment outputs are built
// when BIN2BCD_SEG7_EN is defined.
module bin2bcd_8
    import bin2bcd_8_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        busy,
`ifdef BIN2BCD_SEG7_EN
    output logic [20:0] seg,
`endif
    output logic        done
);

    localparam int WORK_W = BCD_DIGITS * 4 + BIN_W;

    logic [1:0]              state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [WORK_W-1:0]       work_q, work_d;
    logic [11:0]             bcd_q, bcd_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [BCD_DIGITS*4-1:0] adj_digits;
    logic [WORK_W-1:0]       work_shift;

    // One add-3 cell per BCD digit of the working register.
    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (work_q[BIN_W + 4*i +: 4]),
            .dout (adj_digits[4*i +: 4])
        );
    end

    // Corrected digits, then the whole register shifts left by one.
    always_comb begin
        work_shift = {adj_digits[BCD_DIGITS*4-2:0], work_q[BIN_W-1:0], 1'b0};
    end

    // FSM next-state, iteration counter and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        bcd_d   = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (init) begin
                    work_d  = {12'b0, bin};
                    cnt_d   = 3'd0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                work_d = work_shift;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == ITER_LAST) begin
                    bcd_d   = work_shift[WORK_W-1:BIN_W];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Holding init high keeps the result; no retrigger.
                if (!init) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_CONV);
        done_d = (state_d == ST_DONE);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            work_q  <= '0;
            bcd_q   <= 12'h000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef BIN2BCD_SEG7_EN
    logic [20:0] seg_q, seg_d;

    // Segment patterns refresh only on the edge that loads a new result.
    always_comb begin
        seg_d = seg_q;
        if (state_q == ST_CONV && cnt_q == ITER_LAST) begin
            seg_d = {seg7_decode(bcd_d[11:8]),
                     seg7_decode(bcd_d[7:4]),
                     seg7_decode(bcd_d[3:0])};
        end
    end

    // Segment register, blank after reset.
    always_ff @(posedge clk) begin
        if (rst) seg_q <= '0;
        else     seg_q <= seg_d;
    end

    assign seg = seg_q;
`endif

endmodule

// File: tb/tb_bin2bcd_8.sv
// Directed self-checking bench for bin2bcd_8.
module tb_bin2bcd_8;

    logic        clk;
    logic        rst;
    logic        init;
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic        busy;
    logic        done;
`ifdef BIN2BCD_SEG7_EN
    logic [20:0] seg;
`endif

    int checks   = 0;
    int failures = 0;

    bin2bcd_8 dut (
        .clk  (clk),
        .rst  (rst),
        .init (init),
        .bin  (bin),
        .bcd  (bcd),
        .busy (busy),
`ifdef BIN2BCD_SEG7_EN
        .seg  (seg),
`endif
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise init with a value and run until done or a 20-edge bound.
    // cyc = edges after the sampling edge; bcyc = samples with busy high.
    task automatic conv(input logic [7:0] b, output int cyc, output int bcyc);
        init = 1'b1;
        bin  = b;
        step();
        cyc  = 0;
        bcyc = 0;
        while (!done && cyc < 20) begin
            if (busy) bcyc++;
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        init = 1'b0;
        bin  = 8'd0;
        step();
        step();
        checks++;
        if (bcd !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset: bcd=%h busy=%b done=%b want 000/0/0", bcd, busy, done);
        end
`ifdef BIN2BCD_SEG7_EN
        checks++;
        if (seg !== 21'h0) begin
            failures++;
            $display("FAIL reset_seg: seg=%h want 0", seg);
        end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_zero();
        int cyc, bcyc;
        init = 1'b1;
        bin  = 8'd0;
        step();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_busy_e0: busy=%b want 1", busy);
        end
        cyc  = 0;
        bcyc = 0;
        while (!done && cyc < 20) begin
            if (busy) bcyc++;
            step();
            cyc++;
        end
        checks++;
        if (cyc != 8 || bcyc != 8) begin
            failures++;
            $display("FAIL zero_latency: cycles=%0d busy_cycles=%0d want 8/8", cyc, bcyc);
        end
        checks++;
        if (bcd !== 12'h000 || done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_result: bcd=%h done=%b busy=%b want 000/1/0", bcd, done, busy);
        end
        init = 1'b0;
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL zero_done_drop: done=%b want 0", done);
        end
    endtask

    task automatic test_max();
        int cyc, bcyc;
        conv(8'd255, cyc, bcyc);
        checks++;
        if (cyc != 8 || bcd !== 12'h255 || done !== 1'b1) begin
            failures++;
            $display("FAIL max_255: cycles=%0d bcd=%h done=%b want 8/255/1", cyc, bcd, done);
        end
`ifdef BIN2BCD_SEG7_EN
        checks++;
        if (seg !== {7'h5B, 7'h6D, 7'h6D}) begin
            failures++;
            $display("FAIL seg_255: seg=%h want %h", seg, {7'h5B, 7'h6D, 7'h6D});
        end
`endif
        init = 1'b0;
        step();
        conv(8'd225, cyc, bcyc);
        checks++;
        if (cyc != 8 || bcd !== 12'h225) begin
            failures++;
            $display("FAIL max_225: cycles=%0d bcd=%h want 8/225", cyc, bcd);
        end
`ifdef BIN2BCD_SEG7_EN
        checks++;
        if (seg !== {7'h5B, 7'h5B, 7'h6D}) begin
            failures++;
            $display("FAIL seg_225: seg=%h want %h", seg, {7'h5B, 7'h5B, 7'h6D});
        end
`endif
        init = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc;
        conv(8'd99, cyc, bcyc);
        checks++;
        if (bcd !== 12'h099 || done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_99: bcd=%h done=%b want 099/1", bcd, done);
        end
        init = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || bcd !== 12'h099) begin
            failures++;
            $display("FAIL b2b_gap: done=%b busy=%b bcd=%h want 0/0/099", done, busy, bcd);
        end
        conv(8'd100, cyc, bcyc);
        checks++;
        if (cyc != 8 || bcyc != 8 || bcd !== 12'h100) begin
            failures++;
            $display("FAIL b2b_100: cycles=%0d busy_cycles=%0d bcd=%h want 8/8/100", cyc, bcyc, bcd);
        end
        init = 1'b0;
        step();
    endtask

    task automatic test_misc_values();
        int cyc, bcyc;
        logic [7:0]  vin  [3];
        logic [11:0] vexp [3];
        vin[0] = 8'd37;  vexp[0] = 12'h037;
        vin[1] = 8'd128; vexp[1] = 12'h128;
        vin[2] = 8'd9;   vexp[2] = 12'h009;
        for (int i = 0; i < 3; i++) begin
            conv(vin[i], cyc, bcyc);
            checks++;
            if (bcd !== vexp[i] || done !== 1'b1) begin
                failures++;
                $display("FAIL misc_%0d: bcd=%h done=%b want %h/1", vin[i], bcd, done, vexp[i]);
            end
            init = 1'b0;
            step();
        end
    endtask

    task automatic test_hold();
        int cyc, bcyc;
        int bad;
        conv(8'd42, cyc, bcyc);
        checks++;
        if (bcd !== 12'h042 || done !== 1'b1) begin
            failures++;
            $display("FAIL hold_first: bcd=%h done=%b want 042/1", bcd, done);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            bin = 8'(i * 13 + 1);
            step();
            if (done !== 1'b1 || busy !== 1'b0 || bcd !== 12'h042) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_stable: bad_cycles=%0d bcd=%h done=%b busy=%b want 0 bad", bad, bcd, done, busy);
        end
        init = 1'b0;
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL hold_release: done=%b want 0", done);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bcyc;
        init = 1'b1;
        bin  = 8'd200;
        step();
        init = 1'b0;
        repeat (4) step();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_busy: busy=%b want 1", busy);
        end
        rst = 1'b1;
        step();
        checks++;
        if (bcd !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid: bcd=%h busy=%b done=%b want 000/0/0", bcd, busy, done);
        end
        rst = 1'b0;
        repeat (10) step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_idle: busy=%b done=%b want 0/0", busy, done);
        end
        conv(8'd77, cyc, bcyc);
        checks++;
        if (cyc != 8 || bcd !== 12'h077) begin
            failures++;
            $display("FAIL rstmid_after: cycles=%0d bcd=%h want 8/077", cyc, bcd);
        end
        init = 1'b0;
        step();
    endtask

    task automatic test_chain();
        int cyc, bcyc;
        logic [3:0] a, b;
        a = 4'd12;
        b = 4'd13;
        conv(8'(a * b), cyc, bcyc);
        checks++;
        if (bcd !== 12'h156) begin
            failures++;
            $display("FAIL chain_12x13: bcd=%h want 156", bcd);
        end
        init = 1'b0;
        step();
    endtask

    initial begin
        rst  = 1'b1;
        init = 1'b0;
        bin  = 8'd0;
        test_reset();
        test_zero();
        test_max();
        test_back_to_back();
        test_misc_values();
        test_hold();
        test_reset_mid();
        test_chain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
